// File: rtl/pulse_seq_gen.sv
// Purpose : multi-channel timed pulse sequencer. After a start, channel k strobes
//           once per slot of STEP_CYCLES cycles, in order 0..NUM_CH-1; one-shot or looping.
// Latency : sw[k] rises on edge E0+(k+1)*STEP_CYCLES (E0 = start-accept edge); all outputs registered.
// Backpressure: none; start is sampled only while idle and ignored while busy, abort wins over all but rst.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      level, accepted only in IDLE (and only if abort is low)
//   abort      level, returns RUN/FINISH to IDLE on the next edge
//   loop_mode  1 = repeat forever, 0 = one-shot; captured on the start-accept edge
//   sw         channel pulses, at most one bit high at any time
//   ch_idx     channel that fires at the end of the current slot
//   busy       sequence running
//   done       one-cycle completion strobe (one-shot mode only)
//   loop_cnt   (only with PULSE_SEQ_GEN_LOOP_COUNT_EN) count of last-channel pulses, saturating
//
// Optional feature macro: PULSE_SEQ_GEN_LOOP_COUNT_EN adds the loop_cnt output.

module pulse_seq_gen #(
  parameter int NUM_CH      = 2,
  parameter int STEP_CYCLES = 40_000_000,
  parameter int PULSE_W     = 1,
  parameter int CNT_W       = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_mode,
  output logic [NUM_CH-1:0] sw,
  output logic [3:0]        ch_idx,
  output logic              busy,
  output logic              done
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
  ,
  output logic [15:0]       loop_cnt
`endif
);

  // One extra bit so PULSE_W == STEP_CYCLES always fits the pulse-width counter.
  localparam int               PW_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [PW_W-1:0]  PW_LOAD  = PW_W'(PULSE_W);
  localparam logic [PW_W-1:0]  PW_ONE   = PW_W'(1);
  localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PW_W-1:0]   pw, pw_nxt;      // remaining high cycles of the active pulse
  logic              mode, mode_nxt;  // captured loop_mode
  logic              drain, drain_nxt; // one-shot: last pulse issued, waiting for it to fall
  logic [NUM_CH-1:0] sw_nxt;
  logic [3:0]        ch_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              pulse_fall;
  logic              slot_end;
  logic              last_ch;
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
  logic [15:0]       loop_cnt_nxt;
`endif

  // The active pulse ends when its width counter reaches 1 on this edge.
  assign pulse_fall = (sw != '0) && (pw == PW_ONE);
  assign slot_end   = (cnt == CNT_LAST);
  assign last_ch    = (ch_idx == CH_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pw       <= '0;
      mode     <= 1'b0;
      drain    <= 1'b0;
      sw       <= '0;
      ch_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
      loop_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pw       <= pw_nxt;
      mode     <= mode_nxt;
      drain    <= drain_nxt;
      sw       <= sw_nxt;
      ch_idx   <= ch_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
      loop_cnt <= loop_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pw_nxt       = pw;
    mode_nxt     = mode;
    drain_nxt    = drain;
    sw_nxt       = sw;
    ch_nxt       = ch_idx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
    loop_cnt_nxt = loop_cnt;
`endif

    case (state)
      IDLE: begin
        sw_nxt   = '0;
        ch_nxt   = '0;
        busy_nxt = 1'b0;
        if (start && !abort) begin
          state_nxt    = RUN;
          cnt_nxt      = '0;
          pw_nxt       = '0;
          ch_nxt       = '0;
          mode_nxt     = loop_mode;
          drain_nxt    = 1'b0;
          busy_nxt     = 1'b1;
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
          loop_cnt_nxt = '0;
`endif
        end
      end

      RUN: begin
        // Retire the active pulse independently of slot counting, so a pulse
        // may overlap the next slot.
        if (sw != '0) begin
          if (pulse_fall) begin
            sw_nxt = '0;
            pw_nxt = '0;
          end else begin
            pw_nxt = pw - PW_ONE;
          end
        end

        if (drain) begin
          // Counting has stopped; finish once the last pulse is gone.
          if (pulse_fall) begin
            state_nxt = FINISH;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            drain_nxt = 1'b0;
          end
        end else if (slot_end) begin
          // A new rise overrides a fall on the same edge, so with
          // PULSE_W == STEP_CYCLES adjacent pulses abut and stay one-hot.
          cnt_nxt = '0;
          sw_nxt  = NUM_CH'(1) << ch_idx;
          pw_nxt  = PW_LOAD;
          if (last_ch) begin
            ch_nxt = '0;
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
            if (loop_cnt != 16'hFFFF) begin
              loop_cnt_nxt = loop_cnt + 16'd1;
            end
`endif
            if (!mode) begin
              drain_nxt = 1'b1;
            end
          end else begin
            ch_nxt = ch_idx + 4'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      FINISH: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        ch_nxt    = '0;
        sw_nxt    = '0;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        sw_nxt    = '0;
        ch_nxt    = '0;
      end
    endcase

    // Abort overrides everything above; loop_cnt is deliberately kept.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pw_nxt    = '0;
      drain_nxt = 1'b0;
      sw_nxt    = '0;
      ch_nxt    = '0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Purpose : directed self-checking bench for pulse_seq_gen (NUM_CH=3, STEP_CYCLES=10).
// Latency : expectations are written against E0, the edge on which start is accepted.
// Backpressure: n/a; a second instance with PULSE_W=10 covers abutting pulses.

module tb_pulse_seq_gen;

  localparam int NCH  = 3;
  localparam int STEP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       loop_mode;
  logic [2:0] sw;
  logic [3:0] ch_idx;
  logic       busy;
  logic       done;

  logic       start_b;
  logic       abort_b;
  logic       loop_b;
  logic [2:0] sw_b;
  logic [3:0] ch_idx_b;
  logic       busy_b;
  logic       done_b;

`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
  logic [15:0] loop_cnt;
  logic [15:0] loop_cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_seq_gen #(
    .NUM_CH(NCH), .STEP_CYCLES(STEP), .PULSE_W(2), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_mode(loop_mode),
    .sw(sw), .ch_idx(ch_idx), .busy(busy), .done(done)
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
    , .loop_cnt(loop_cnt)
`endif
  );

  pulse_seq_gen #(
    .NUM_CH(NCH), .STEP_CYCLES(STEP), .PULSE_W(10), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .loop_mode(loop_b),
    .sw(sw_b), .ch_idx(ch_idx_b), .busy(busy_b), .done(done_b)
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
    , .loop_cnt(loop_cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it; inputs are also changed here.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected sw k cycles after E0 for pulse width w.
  function automatic logic [2:0] exp_sw(input int k, input int w, input bit lp);
    int         j;
    logic [2:0] one;
    one = 3'b001;
    if (k < STEP) return 3'b000;
    j = k / STEP - 1;
    if (!lp && j >= NCH) return 3'b000;
    if ((k % STEP) >= w) return 3'b000;
    return one << (j % NCH);
  endfunction

  // One-shot sequence on dut_a; optionally re-assert start at E0+5.
  task automatic run_os(input string name, input bit retrig);
    start = 1'b1;
    loop_mode = 1'b0;
    tick;
    start = 1'b0;
    chk({name, "_busy_e0"}, 32'(busy), 32'd1);
    chk({name, "_ch_e0"}, 32'(ch_idx), 32'd0);
    for (int k = 1; k <= 35; k++) begin
      start = retrig && (k == 5);
      tick;
      chk($sformatf("%s_sw_k%0d", name, k), 32'(sw), 32'(exp_sw(k, 2, 1'b0)));
      chk($sformatf("%s_done_k%0d", name, k), 32'(done), 32'(k == 32));
      chk($sformatf("%s_busy_k%0d", name, k), 32'(busy), 32'(k < 32));
      if (k < 30) chk($sformatf("%s_ch_k%0d", name, k), 32'(ch_idx), 32'((k / STEP) % NCH));
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_mode = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; loop_b = 1'b0;
    tick;
    tick;
    chk("rst_sw", 32'(sw), 32'd0);
    chk("rst_ch", 32'(ch_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sw_b", 32'(sw_b), 32'd0);
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
    chk("rst_loop_cnt", 32'(loop_cnt), 32'd0);
`endif
    rst = 1'b0;
    tick;

    // Plain one-shot, then one with start re-asserted while busy.
    run_os("os", 1'b0);
    run_os("retrig", 1'b1);

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    tick;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_sw", 32'(sw), 32'd0);
    start = 1'b0; abort = 1'b0;
    tick;
    chk("sa_busy2", 32'(busy), 32'd0);

    // Loop mode for 70 cycles.
    start = 1'b1; loop_mode = 1'b1;
    tick;
    start = 1'b0; loop_mode = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick;
      chk($sformatf("loop_sw_k%0d", k), 32'(sw), 32'(exp_sw(k, 2, 1'b1)));
      chk($sformatf("loop_ch_k%0d", k), 32'(ch_idx), 32'((k / STEP) % NCH));
      chk($sformatf("loop_busy_k%0d", k), 32'(busy), 32'd1);
      chk($sformatf("loop_done_k%0d", k), 32'(done), 32'd0);
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
      if (k == 59) chk("loop_cnt_k59", 32'(loop_cnt), 32'd1);
      if (k == 60) chk("loop_cnt_k60", 32'(loop_cnt), 32'd2);
`endif
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("loop_ab_sw", 32'(sw), 32'd0);
    chk("loop_ab_busy", 32'(busy), 32'd0);
    chk("loop_ab_ch", 32'(ch_idx), 32'd0);
    chk("loop_ab_done", 32'(done), 32'd0);
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
    chk("loop_cnt_held", 32'(loop_cnt), 32'd2);
`endif
    tick;

    // Abort sampled at E0+15 during RUN.
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick;
      chk($sformatf("ab_sw_k%0d", k), 32'(sw), 32'(exp_sw(k, 2, 1'b0)));
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_sw", 32'(sw), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ch", 32'(ch_idx), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      tick;
      chk($sformatf("ab_quiet_sw_k%0d", k), 32'(sw), 32'd0);
      chk($sformatf("ab_quiet_done_k%0d", k), 32'(done), 32'd0);
      chk($sformatf("ab_quiet_busy_k%0d", k), 32'(busy), 32'd0);
    end

    // rst during the sw[1] pulse, then a fresh sequence from slot 0.
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      chk($sformatf("rr_sw_k%0d", k), 32'(sw), 32'(exp_sw(k, 2, 1'b0)));
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rr_sw", 32'(sw), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_ch", 32'(ch_idx), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    tick;
    run_os("rr_restart", 1'b0);

    // start held high in one-shot: restart on the edge after FINISH.
    start = 1'b1; loop_mode = 1'b0;
    tick;
    for (int k = 1; k <= 44; k++) begin
      tick;
      if (k == 32) chk("hold_done_k32", 32'(done), 32'd1);
      if (k == 33) chk("hold_busy_k33", 32'(busy), 32'd0);
      if (k == 33) chk("hold_done_k33", 32'(done), 32'd0);
      if (k == 34) begin
        chk("hold_busy_k34", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (k == 43) chk("hold_sw_k43", 32'(sw), 32'd0);
      if (k == 44) chk("hold_sw_k44", 32'(sw), 32'd1);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("hold_ab_busy", 32'(busy), 32'd0);

    // PULSE_W == STEP_CYCLES: abutting, one-hot pulses.
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      tick;
      chk($sformatf("pw10_sw_k%0d", k), 32'(sw_b), 32'(exp_sw(k, 10, 1'b0)));
      if (k >= 10 && k <= 39)
        chk($sformatf("pw10_onehot_k%0d", k), 32'($countones(sw_b)), 32'd1);
      chk($sformatf("pw10_done_k%0d", k), 32'(done_b), 32'(k == 40));
      chk($sformatf("pw10_busy_k%0d", k), 32'(busy_b), 32'(k < 40));
    end
    chk("pw10_ch_end", 32'(ch_idx_b), 32'd0);
`ifdef PULSE_SEQ_GEN_LOOP_COUNT_EN
    chk("pw10_loop_cnt", 32'(loop_cnt_b), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
